// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART TX/RX blocks and the TX arbiter.
//   - uart_arb_state_t : arbiter FSM state encoding
//   - UART_HDR_BASE    : base value of the per-packet header byte (OR'd with
//                        the owner index)
//   - IDLE_CNT_W       : width of the arbiter's stalled-owner counter
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARB       = 3'd1,
        ST_HDR       = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_DONE = 3'd4
    } uart_arb_state_t;

    localparam logic [7:0]  UART_HDR_BASE = 8'hA0;
    localparam int unsigned IDLE_CNT_W    = 16;

    // Header byte announcing which requester owns the following packet.
    function automatic logic [7:0] uart_hdr_byte(input logic [3:0] idx);
        return UART_HDR_BASE | {4'h0, idx};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin priority search. Returns a one-hot grant for the
//   first asserted request found searching upward from 'pointer', wrapping
//   from N-1 back to 0. All-zero when no request is asserted.
//
//   Parameters : N       - number of requesters (>= 2)
//   Ports      : req     [N-1:0]         request vector
//                pointer [$clog2(N)-1:0] highest-priority index (< N)
//                gnt     [N-1:0]         one-hot grant
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] pointer,
    output logic [N-1:0]         gnt
);

    logic [2*N-1:0] req_rot;
    logic [N-1:0]   gnt_rot;
    logic [2*N-1:0] gnt_dbl;
    logic           found;

    // Rotate so the pointer position sits at bit 0, take the lowest set bit,
    // then rotate the one-hot result back into requester order.
    always_comb begin
        req_rot = {req, req} >> pointer;
        gnt_rot = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req_rot[i]) begin
                gnt_rot[i] = 1'b1;
                found      = 1'b1;
            end
        end
        gnt_dbl = {{N{1'b0}}, gnt_rot} << pointer;
        gnt     = gnt_dbl[N-1:0] | gnt_dbl[2*N-1:N];
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Packet-level round-robin arbiter feeding one UART transmitter. A granted
//   requester owns the transmitter until its last byte completes or it stalls
//   for IDLE_TIMEOUT cycles. One byte is in flight at a time: each byte is
//   strobed with o_TX_DV and the next is not taken until i_TX_Done.
//
//   Parameters : NUM_REQ      - number of requesters (2..16)
//                IDLE_TIMEOUT - stalled-owner cycles before release (0 = never)
//   Ports      : i_clk        clock, rising edge
//                i_rst_n      synchronous active-low reset
//                i_req_valid  [NUM_REQ]    requester k has a byte
//                i_req_data   [8*NUM_REQ]  byte of requester k at [8k+7:8k]
//                i_req_last   [NUM_REQ]    byte ends requester k's packet
//                o_req_ready  [NUM_REQ]    byte accept (owner bit, SEND only)
//                o_TX_Byte    [8]          byte to transmitter (held)
//                o_TX_DV                   one-cycle strobe for o_TX_Byte
//                i_TX_Done                 transmitter completion pulse
//                o_grant      [NUM_REQ]    one-hot packet owner
//                o_busy                    high outside IDLE
//   Build option: define UART_ARB_HDR_EN to prefix each packet with header
//                 byte 8'hA0 | owner index.
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned IDLE_TIMEOUT = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]   i_req_last,
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic [7:0]           o_TX_Byte,
    output logic                 o_TX_DV,
    input  logic                 i_TX_Done,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic                 o_busy
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    uart_arb_state_t       state;
    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         owner;
    logic [IDLE_CNT_W-1:0] idle_cnt;
    logic                  byte_last;
    logic                  hdr_inflight;

    logic [NUM_REQ-1:0]    arb_gnt;
    logic [PW-1:0]         arb_idx;
    logic                  owner_valid;
    logic                  owner_last;
    logic [7:0]            owner_data;
    logic                  accept;
    logic [PW-1:0]         next_ptr;
    logic [IDLE_CNT_W-1:0] idle_inc;
    logic                  timeout_hit;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req     (i_req_valid),
        .pointer (rr_ptr),
        .gnt     (arb_gnt)
    );

    always_comb begin
        arb_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) arb_idx = PW'(i);
        end
    end

    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner == PW'(i)) begin
                owner_valid = i_req_valid[i];
                owner_last  = i_req_last[i];
                owner_data  = i_req_data[i*8 +: 8];
            end
        end
    end

    assign o_req_ready = (state == ST_SEND) ? o_grant : '0;
    assign accept      = (state == ST_SEND) && owner_valid;
    assign o_busy      = (state != ST_IDLE);
    assign next_ptr    = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign idle_inc    = idle_cnt + 1'b1;
    assign timeout_hit = (IDLE_TIMEOUT != 0) && (32'(idle_inc) == IDLE_TIMEOUT);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            o_grant      <= '0;
            o_TX_Byte    <= '0;
            o_TX_DV      <= 1'b0;
            idle_cnt     <= '0;
            byte_last    <= 1'b0;
            hdr_inflight <= 1'b0;
        end else begin
            o_TX_DV <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|i_req_valid) state <= ST_ARB;
                end

                ST_ARB: begin
                    if (|arb_gnt) begin
                        o_grant  <= arb_gnt;
                        owner    <= arb_idx;
                        idle_cnt <= '0;
`ifdef UART_ARB_HDR_EN
                        state    <= ST_HDR;
`else
                        state    <= ST_SEND;
`endif
                    end else begin
                        o_grant <= '0;
                        state   <= ST_IDLE;
                    end
                end

                ST_HDR: begin
`ifdef UART_ARB_HDR_EN
                    o_TX_Byte    <= uart_hdr_byte(4'(owner));
                    o_TX_DV      <= 1'b1;
                    hdr_inflight <= 1'b1;
                    state        <= ST_WAIT_DONE;
`else
                    state        <= ST_IDLE;
`endif
                end

                ST_SEND: begin
                    if (accept) begin
                        o_TX_Byte    <= owner_data;
                        o_TX_DV      <= 1'b1;
                        byte_last    <= owner_last;
                        hdr_inflight <= 1'b0;
                        idle_cnt     <= '0;
                        state        <= ST_WAIT_DONE;
                    end else if (timeout_hit) begin
                        // Stalled owner is treated exactly like a finished packet.
                        rr_ptr   <= next_ptr;
                        o_grant  <= '0;
                        idle_cnt <= '0;
                        state    <= ST_ARB;
                    end else if (idle_cnt != '1) begin
                        idle_cnt <= idle_inc;
                    end
                end

                ST_WAIT_DONE: begin
                    if (i_TX_Done) begin
                        if (hdr_inflight) begin
                            hdr_inflight <= 1'b0;
                            idle_cnt     <= '0;
                            state        <= ST_SEND;
                        end else if (byte_last) begin
                            rr_ptr  <= next_ptr;
                            o_grant <= '0;
                            state   <= ST_ARB;
                        end else begin
                            idle_cnt <= '0;
                            state    <= ST_SEND;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Scoreboard bench for uart_tx_arbiter (NUM_REQ=4, IDLE_TIMEOUT=8).
//   Stimulus pushes the expected DV byte/grant pairs; a monitor pops and
//   compares on every o_TX_DV. A transmitter model answers each DV with
//   i_TX_Done five cycles later. Header expectations are added when
//   UART_ARB_HDR_EN is defined.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_byte;
    logic        tx_dv;
    logic        tx_done;
    logic [3:0]  grant;
    logic        busy;
    logic        done_auto = 1'b0;
    logic        done_man  = 1'b0;

    always #5 clk = ~clk;
    assign tx_done = done_auto | done_man;

    uart_tx_arbiter #(.NUM_REQ(4), .IDLE_TIMEOUT(8)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_last  (req_last),
        .o_req_ready (req_ready),
        .o_TX_Byte   (tx_byte),
        .o_TX_DV     (tx_dv),
        .i_TX_Done   (tx_done),
        .o_grant     (grant),
        .o_busy      (busy)
    );

    typedef struct packed { logic [7:0] data; logic last; } item_t;
    typedef struct packed { logic [7:0] data; logic [3:0] g; } exp_t;

    item_t rq[4][$];
    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    stall0 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_item(input int k, input logic [7:0] d, input logic l);
        rq[k].push_back('{d, l});
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [3:0] g);
        exp_q.push_back('{d, g});
    endtask

    task automatic exp_hdr(input int k);
`ifdef UART_ARB_HDR_EN
        exp_q.push_back('{8'hA0 | 8'(k), 4'(1 << k)});
`endif
    endtask

    function automatic bit pending();
        return exp_q.size() != 0 || busy !== 1'b0 || rq[0].size() != 0 ||
               rq[1].size() != 0 || rq[2].size() != 0 || rq[3].size() != 0;
    endfunction

    task automatic check_reset_outs(input string tag);
        chk({tag, "_ready"}, {28'h0, req_ready}, 32'h0);
        chk({tag, "_dv"},    {31'h0, tx_dv},     32'h0);
        chk({tag, "_grant"}, {28'h0, grant},     32'h0);
        chk({tag, "_busy"},  {31'h0, busy},      32'h0);
        chk({tag, "_byte"},  {24'h0, tx_byte},   32'h0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) rq[k].delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outs(tag);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (pending() && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=%0d pending_bytes required=0", tag, exp_q.size());
        end
    endtask

    task automatic wait_grant(input string tag, input logic [3:0] g, input int budget);
        int n = 0;
        while (grant !== g && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_grant_seen"}, {28'h0, grant}, {28'h0, g});
    endtask

    // Requester model: presents the head of each queue, pops on accepted bytes.
    initial begin
        logic [3:0] acc;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (acc[k] && rq[k].size() > 0) void'(rq[k].pop_front());
                if (rq[k].size() > 0) begin
                    req_valid[k]       = 1'b1;
                    req_data[k*8 +: 8] = rq[k][0].data;
                    req_last[k]        = rq[k][0].last;
                end else begin
                    req_valid[k] = 1'b0;
                    req_last[k]  = 1'b0;
                end
            end
        end
    end

    // Transmitter model: completion pulse five cycles after each strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_dv === 1'b1) begin
                repeat (5) @(posedge clk);
                #1 done_auto = 1'b1;
                @(posedge clk);
                #1 done_auto = 1'b0;
            end
        end
    end

    // Monitor: every strobe must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tx_dv !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dv_unexpected actual=strobe byte %0h required=no strobe", tx_byte);
                end else begin
                    e = exp_q.pop_front();
                    chk("dv_byte",  {24'h0, tx_byte}, {24'h0, e.data});
                    chk("dv_grant", {28'h0, grant},   {28'h0, e.g});
                end
            end
        end
    end

    // Counts SEND cycles where requester 0 owns the grant but is not valid.
    initial begin
        forever begin
            @(negedge clk);
            if (req_ready[0] === 1'b1 && req_valid[0] === 1'b0) stall0++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=not finished required=finished");
        $fatal(1);
    end

    initial begin
        int s0;
        int n;
        rst_n = 1'b0;

        // Reset state
        do_reset("reset_state");

        // Single packet from requester 2
        do_reset("single_rst");
        push_item(2, 8'h11, 1'b0);
        push_item(2, 8'h22, 1'b1);
        exp_hdr(2);
        push_exp(8'h11, 4'b0100);
        push_exp(8'h22, 4'b0100);
        wait_idle("single", 400);
        chk("single_idle_grant", {28'h0, grant}, 32'h0);
        chk("single_idle_busy",  {31'h0, busy},  32'h0);

        // Fairness: two 1-byte packets per requester, all valid from reset
        do_reset("fair_rst");
        push_item(0, 8'h10, 1'b1); push_item(0, 8'h11, 1'b1);
        push_item(1, 8'h20, 1'b1); push_item(1, 8'h21, 1'b1);
        push_item(2, 8'h30, 1'b1); push_item(2, 8'h31, 1'b1);
        push_item(3, 8'h40, 1'b1); push_item(3, 8'h41, 1'b1);
        exp_hdr(0); push_exp(8'h10, 4'b0001);
        exp_hdr(1); push_exp(8'h20, 4'b0010);
        exp_hdr(2); push_exp(8'h30, 4'b0100);
        exp_hdr(3); push_exp(8'h40, 4'b1000);
        exp_hdr(0); push_exp(8'h11, 4'b0001);
        exp_hdr(1); push_exp(8'h21, 4'b0010);
        exp_hdr(2); push_exp(8'h31, 4'b0100);
        exp_hdr(3); push_exp(8'h41, 4'b1000);
        wait_idle("fair", 1200);

        // Hold: requester 1 keeps the grant while requester 0 becomes valid
        do_reset("hold_rst");
        push_item(1, 8'h31, 1'b0);
        push_item(1, 8'h32, 1'b0);
        push_item(1, 8'h33, 1'b1);
        exp_hdr(1);
        push_exp(8'h31, 4'b0010);
        push_exp(8'h32, 4'b0010);
        push_exp(8'h33, 4'b0010);
        wait_grant("hold", 4'b0010, 20);
        push_item(0, 8'h0F, 1'b1);
        exp_hdr(0);
        push_exp(8'h0F, 4'b0001);
        wait_idle("hold", 600);

        // Timeout: requester 0 stalls after one byte, requester 1 waiting
        do_reset("tmo_rst");
        s0 = stall0;
        push_item(0, 8'h01, 1'b0);
        push_item(1, 8'h77, 1'b1);
        exp_hdr(0); push_exp(8'h01, 4'b0001);
        exp_hdr(1); push_exp(8'h77, 4'b0010);
        wait_idle("tmo", 600);
        chk("tmo_idle_cycles", 32'(stall0 - s0), 32'd8);

        // Requester 3 single byte (header 0xA3 first when enabled)
        do_reset("hdr_rst");
        push_item(3, 8'h5A, 1'b1);
        exp_hdr(3);
        push_exp(8'h5A, 4'b1000);
        wait_idle("hdr", 400);

        // Reset during WAIT_DONE, then completion pulses while IDLE
        do_reset("rdone_rst");
        push_item(0, 8'h33, 1'b1);
        exp_hdr(0);
        push_exp(8'h33, 4'b0001);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rdone_dv_seen", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("rdone_busy_wait", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outs("rdone_in_rst");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1 done_man = 1'b1;
        @(posedge clk);
        #1 done_man = 1'b0;
        repeat (10) @(negedge clk);
        check_reset_outs("rdone_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
